burst_src: RTL and testbench

BURST_SRC -- requirements
Module: burst_src

---
 rtl/burst_src.sv | 158 +++++++++++++++
 tb/tb_burst_src.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_src.sv
// -----------------------------------------------------------------------------
// burst_src -- arithmetic burst generator
//
// Accepts a command (base, step, len) with a valid/ready handshake and emits
// len+1 bytes on a valid/ready output stream. Beat k carries
// (base + k*step) mod 256. out_last flags the final beat of the burst.
//
// Optional feature (macro CHECKSUM_EN): after the data beats, one extra beat
// carries the mod-256 sum of all data beats. In that build out_last marks only
// this checksum beat.
//
// Ports:
//   clk       in   clock, all state changes on the rising edge
//   rst       in   synchronous active-high reset
//   cmd_srdy  in   command valid
//   cmd_base  in   [7:0] first data byte
//   cmd_step  in   [7:0] per-beat increment
//   cmd_len   in   [3:0] burst length minus one
//   cmd_rrdy  out  command can be accepted (IDLE only)
//   out_srdy  out  out_data valid
//   out_data  out  [7:0] burst byte
//   out_last  out  final beat of burst
//   out_rrdy  in   downstream accepts beat
//   busy      out  burst in progress
// -----------------------------------------------------------------------------
module burst_src (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_srdy,
    input  logic [7:0] cmd_base,
    input  logic [7:0] cmd_step,
    input  logic [3:0] cmd_len,
    output logic       cmd_rrdy,
    output logic       out_srdy,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_rrdy,
    output logic       busy
);

`ifdef CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, CSUM = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

    state_t     state_reg;
    logic [7:0] data_reg;
    logic [7:0] step_reg;
    logic [3:0] len_reg;
    logic [3:0] cnt_reg;
    logic       last_reg;
    logic       srdy_reg;
    logic       cmd_rrdy_reg;
    logic       busy_reg;
`ifdef CHECKSUM_EN
    logic [7:0] csum_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            data_reg     <= 8'h00;
            step_reg     <= 8'h00;
            len_reg      <= 4'd0;
            cnt_reg      <= 4'd0;
            last_reg     <= 1'b0;
            srdy_reg     <= 1'b0;
            cmd_rrdy_reg <= 1'b1;
            busy_reg     <= 1'b0;
`ifdef CHECKSUM_EN
            csum_reg     <= 8'h00;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    // cmd_rrdy is high throughout IDLE, so cmd_srdy alone
                    // completes the handshake here.
                    if (cmd_srdy) begin
                        state_reg    <= SEND;
                        data_reg     <= cmd_base;
                        step_reg     <= cmd_step;
                        len_reg      <= cmd_len;
                        cnt_reg      <= 4'd0;
                        srdy_reg     <= 1'b1;
                        cmd_rrdy_reg <= 1'b0;
                        busy_reg     <= 1'b1;
`ifdef CHECKSUM_EN
                        csum_reg     <= 8'h00;
                        last_reg     <= 1'b0;
`else
                        // A single-beat burst is already on its last beat.
                        last_reg     <= (cmd_len == 4'd0);
`endif
                    end
                end

                SEND: begin
                    // Outputs only move on a transfer, so a stalled beat
                    // stays stable.
                    if (out_rrdy) begin
`ifdef CHECKSUM_EN
                        csum_reg <= csum_reg + data_reg;
`endif
                        if (cnt_reg == len_reg) begin
`ifdef CHECKSUM_EN
                            // The beat being transferred is not yet in
                            // csum_reg, so fold it in here.
                            state_reg <= CSUM;
                            data_reg  <= csum_reg + data_reg;
                            last_reg  <= 1'b1;
`else
                            state_reg    <= IDLE;
                            srdy_reg     <= 1'b0;
                            last_reg     <= 1'b0;
                            cmd_rrdy_reg <= 1'b1;
                            busy_reg     <= 1'b0;
`endif
                        end else begin
                            cnt_reg  <= cnt_reg + 4'd1;
                            data_reg <= data_reg + step_reg;
`ifndef CHECKSUM_EN
                            last_reg <= ((cnt_reg + 4'd1) == len_reg);
`endif
                        end
                    end
                end

`ifdef CHECKSUM_EN
                CSUM: begin
                    if (out_rrdy) begin
                        state_reg    <= IDLE;
                        srdy_reg     <= 1'b0;
                        last_reg     <= 1'b0;
                        cmd_rrdy_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                    end
                end
`endif

                default: begin
                    state_reg    <= IDLE;
                    srdy_reg     <= 1'b0;
                    last_reg     <= 1'b0;
                    cmd_rrdy_reg <= 1'b1;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_rrdy = cmd_rrdy_reg;
    assign out_srdy = srdy_reg;
    assign out_data = data_reg;
    assign out_last = last_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_burst_src.sv
// -----------------------------------------------------------------------------
// tb_burst_src -- directed self-checking bench for burst_src.
// Works with and without CHECKSUM_EN defined.
// -----------------------------------------------------------------------------
module tb_burst_src;

    logic       clk;
    logic       rst;
    logic       cmd_srdy;
    logic [7:0] cmd_base;
    logic [7:0] cmd_step;
    logic [3:0] cmd_len;
    logic       cmd_rrdy;
    logic       out_srdy;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_rrdy;
    logic       busy;

    int checks;
    int failures;

`ifdef CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    burst_src dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_srdy (cmd_srdy),
        .cmd_base (cmd_base),
        .cmd_step (cmd_step),
        .cmd_len  (cmd_len),
        .cmd_rrdy (cmd_rrdy),
        .out_srdy (out_srdy),
        .out_data (out_data),
        .out_last (out_last),
        .out_rrdy (out_rrdy),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_srdy"}, {7'd0, out_srdy}, 8'd0);
        chk({tag, "_rrdy"}, {7'd0, cmd_rrdy}, 8'd1);
        chk({tag, "_busy"}, {7'd0, busy},     8'd0);
    endtask

    task automatic chk_beat(input string tag, input logic [7:0] d, input logic l);
        chk({tag, "_srdy"}, {7'd0, out_srdy}, 8'd1);
        chk({tag, "_data"}, out_data,         d);
        chk({tag, "_last"}, {7'd0, out_last}, {7'd0, l});
        $display("beat %s data=%02h last=%0b", tag, out_data, out_last);
    endtask

    // Issue one command and accept it on the next edge; out_rrdy held high.
    task automatic issue(input logic [7:0] b, input logic [7:0] s, input logic [3:0] l);
        chk("cmd_rrdy_before_accept", {7'd0, cmd_rrdy}, 8'd1);
        cmd_srdy = 1'b1;
        cmd_base = b;
        cmd_step = s;
        cmd_len  = l;
        tick();
        cmd_srdy = 1'b0;
        $display("cmd base=%02h step=%02h len=%0d", b, s, l);
    endtask

    // Full burst with no back-pressure; beats and checksum are hand-supplied.
    task automatic run_burst(input string tag, input logic [7:0] b, input logic [7:0] s,
                             input logic [3:0] l, input logic [7:0] beats[16],
                             input logic [7:0] csum);
        out_rrdy = 1'b1;
        issue(b, s, l);
        for (int k = 0; k <= int'(l); k++) begin
            chk_beat($sformatf("%s_b%0d", tag, k), beats[k], (k == int'(l)) && !CS);
            chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
            tick();
        end
        if (CS) begin
            chk_beat({tag, "_csum"}, csum, 1'b1);
            tick();
        end
        chk_idle({tag, "_end"});
    endtask

    logic [7:0] exp_beats[16];

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        cmd_srdy = 1'b0;
        cmd_base = 8'h00;
        cmd_step = 8'h00;
        cmd_len  = 4'd0;
        out_rrdy = 1'b0;
        exp_beats = '{default: 8'h00};
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk_idle("reset");
        chk("reset_data", out_data, 8'h00);
        chk("reset_last", {7'd0, out_last}, 8'd0);

        // Incrementing burst 10..13
        exp_beats[0:3] = '{8'h10, 8'h11, 8'h12, 8'h13};
        run_burst("inc", 8'h10, 8'h01, 4'd3, exp_beats, 8'h46);

        // Wrapping burst FE,FF,00,01
        exp_beats[0:3] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        run_burst("wrap", 8'hFE, 8'h01, 4'd3, exp_beats, 8'hFE);

        // Back-pressure on beat 1: 24 held for 3 stalled cycles
        out_rrdy = 1'b1;
        issue(8'h20, 8'h04, 4'd2);
        chk_beat("bp_b0", 8'h20, 1'b0);
        tick();
        out_rrdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_beat($sformatf("bp_hold%0d", i), 8'h24, 1'b0);
            tick();
        end
        chk_beat("bp_b1", 8'h24, 1'b0);
        out_rrdy = 1'b1;
        tick();
        chk_beat("bp_b2", 8'h28, !CS);
        tick();
        if (CS) begin
            chk_beat("bp_csum", 8'h6C, 1'b1);
            tick();
        end
        chk_idle("bp_end");

        // Command pulsed while busy is ignored
        issue(8'h30, 8'h01, 4'd3);
        chk_beat("busy_b0", 8'h30, 1'b0);
        tick();
        cmd_srdy = 1'b1;
        cmd_base = 8'hAA;
        cmd_step = 8'h01;
        cmd_len  = 4'd1;
        chk("busy_cmd_rrdy", {7'd0, cmd_rrdy}, 8'd0);
        chk_beat("busy_b1", 8'h31, 1'b0);
        tick();
        cmd_srdy = 1'b0;
        chk_beat("busy_b2", 8'h32, 1'b0);
        tick();
        chk_beat("busy_b3", 8'h33, !CS);
        tick();
        if (CS) begin
            chk_beat("busy_csum", 8'hC6, 1'b1);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk_idle($sformatf("busy_noaa%0d", i));
            tick();
        end

        // Reset during beat 2 of a len=7 burst
        issue(8'h40, 8'h01, 4'd7);
        chk_beat("rst_b0", 8'h40, 1'b0);
        tick();
        chk_beat("rst_b1", 8'h41, 1'b0);
        tick();
        chk_beat("rst_b2", 8'h42, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("rst_mid");
        chk("rst_mid_data", out_data, 8'h00);
        chk("rst_mid_last", {7'd0, out_last}, 8'd0);
        tick();
        chk_idle("rst_after");

        // Reset wins over a simultaneous handshake
        rst      = 1'b1;
        cmd_srdy = 1'b1;
        cmd_base = 8'h77;
        cmd_len  = 4'd2;
        tick();
        rst      = 1'b0;
        cmd_srdy = 1'b0;
        chk_idle("rst_prio");

        // Single-beat burst after reset
        exp_beats[0] = 8'h05;
        run_burst("single", 8'h05, 8'h01, 4'd0, exp_beats, 8'h05);

        // Back-to-back commands with cmd_srdy held high
        issue(8'h50, 8'h02, 4'd1);
        cmd_srdy = 1'b1;
        cmd_base = 8'h60;
        cmd_step = 8'h03;
        cmd_len  = 4'd1;
        chk_beat("b2b_a0", 8'h50, 1'b0);
        tick();
        chk("b2b_a1_rrdy", {7'd0, cmd_rrdy}, 8'd0);
        chk_beat("b2b_a1", 8'h52, !CS);
        tick();
        if (CS) begin
            chk_beat("b2b_acsum", 8'hA2, 1'b1);
            tick();
        end
        chk_idle("b2b_gap");
        tick();
        cmd_srdy = 1'b0;
        chk_beat("b2b_b0", 8'h60, 1'b0);
        chk("b2b_b0_busy", {7'd0, busy}, 8'd1);
        tick();
        chk_beat("b2b_b1", 8'h63, !CS);
        tick();
        if (CS) begin
            chk_beat("b2b_bcsum", 8'hC3, 1'b1);
            tick();
        end
        chk_idle("b2b_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
